ultrasonic_ranger: RTL and testbench
====================================

# ultrasonic_ranger

Single-shot HC-SR04 measurement engine. On a `start` request it issues the trigger pulse, times the echo pulse with a timeout, and converts the echo width directly to centimetres. The result is presented with a one-cycle valid strobe. It replaces the free-running trigger and echo counter pair and feeds the 7-segment and servo-sweep logic downstream with one distance per servo step.

## Interface
Parameters:
- `TRIG_CYCLES`, 270: trigger high time in clocks (10 µs at 27 MHz).
- `CYCLES_PER_CM`, 1574: clocks of echo-high per centimetre of range (58.3 µs).
- `TIMEOUT_CYCLES`, 1026000: maximum wait for echo rise, and maximum echo-high duration (38 ms).
- `HOLDOFF_CYCLES`, 1620000: quiet time after each measurement before the next trigger (60 ms).
- `MAX_CM`, 1023: saturation value of `distance_cm`.

Ports:
- `clk`, in, 1: system clock, 27 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: measurement request; level-sampled in IDLE only.
- `ech`, in, 1: echo from sensor; asynchronous.
- `trig`, out, 1: trigger to sensor.
- `busy`, out, 1: high in every state except IDLE.
- `distance_cm`, out, 10: last result; held until the next result.
- `dist_valid`, out, 1: one-cycle strobe, new result on `distance_cm`.
- `timeout`, out, 1: one-cycle strobe, measurement aborted; asserted in the same cycle as `dist_valid`.

## Operation
- `ech` passes through a 2-flop synchronizer and then a rise/fall detector. The synchronized value is `ech_s`.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLDOFF.
- IDLE: `start`=1 moves to TRIG. The trigger counter, prescaler, accumulator and timeout counter are cleared.
- TRIG: `trig`=1 for exactly TRIG_CYCLES clocks, then WAIT_RISE.
- WAIT_RISE: timeout counter increments each clock.
  - A rise of `ech_s` moves to MEASURE, with the prescaler and accumulator at 0.
  - Counter reaching TIMEOUT_CYCLES-1 with no rise: result = MAX_CM, timeout flag set, go to DONE.
  - If `ech_s` is already high on entry to WAIT_RISE, this is not a rise; the block waits for a genuine edge.
- MEASURE: prescaler increments each clock that `ech_s`=1.
  - When the prescaler reaches CYCLES_PER_CM-1, it wraps to 0 and the accumulator increments, saturating at MAX_CM.
  - A fall of `ech_s` gives result = accumulator (truncated, not rounded), then DONE.
  - Echo-high counter reaching TIMEOUT_CYCLES-1 gives result = MAX_CM and the timeout flag.
- DONE (one cycle): `distance_cm` is loaded, `dist_valid`=1, and `timeout` equals the flag. Then HOLDOFF.
- HOLDOFF: wait HOLDOFF_CYCLES clocks, then IDLE. `start` is ignored in HOLDOFF; requests are not queued.
- Arithmetic: counters are unsigned, and each is sized by `$clog2` of its terminal value. No multiplier or divider is used.
- Reset: state IDLE.
  - Outputs: `trig`=0, `busy`=0, `dist_valid`=0, `timeout`=0, `distance_cm`=0.
  - Internal: synchronizer flops 0, all counters 0.
  - Reset mid-TRIG drops `trig` on the next edge.
  - Any echo after reset is ignored until the next TRIG completes.

## Timing
- `start` sampled high at edge N: `trig` and `busy` are high from edge N+1. `trig` falls at edge N+1+TRIG_CYCLES.
- The synchronizer plus edge detector give a 3-clock latency from a pin edge to the state action. Rise and fall are delayed equally, so the measured width is unaffected.
- Echo width W clocks gives `distance_cm` = min(floor(W / CYCLES_PER_CM), MAX_CM), ±1 clock of quantization.
- `dist_valid` asserts 4 clocks after the `ech` pin falls. `busy` stays high through HOLDOFF and drops on the IDLE entry edge.
- Minimum start-to-start period = TRIG_CYCLES + echo time + 1 + HOLDOFF_CYCLES + 1.

## Structure
- `ranger_pkg`: state enum `ranger_state_t`, default parameter constants, and `DIST_W = 10`.
- Sub-module `echo_sync`: 2-flop synchronizer with registered `rise`/`fall` pulses, reset by `rst`. It is reused for the future second sensor.
- `ultrasonic_ranger` contains the FSM, counters and output registers only.

## Test plan
Bench overrides: TRIG_CYCLES=10, CYCLES_PER_CM=20, TIMEOUT_CYCLES=2000, HOLDOFF_CYCLES=50, MAX_CM=63.
- Basic: `start` 1 clock; echo rises 30 clocks after `trig` falls and stays high 200 clocks. Required: `trig` high exactly 10 clocks, `distance_cm`=10, one `dist_valid`, `timeout`=0.
- Quantization: echo widths 19, 20, 39 and 40 clocks. Required: `distance_cm` = 0, 1, 1, 2.
- No echo: echo held low. Required: `dist_valid`=`timeout`=1 together, 2000 clocks after `trig` falls; `distance_cm`=63.
- Stuck echo: echo high 3000 clocks. Required: `timeout`=1 and `distance_cm`=63; a later clean measurement of 100 clocks yields 5.
- Saturation: echo 1300 clocks (65 cm), within timeout. Required: `distance_cm`=63, `timeout`=0.
- Reset/ignore: `rst` asserted mid-TRIG, giving `trig`=0 next clock and all outputs at reset values. `start` held during HOLDOFF starts a new TRIG only on IDLE entry.

Source files
------------

// File: rtl/ranger_pkg.sv
// Shared types and default constants for the HC-SR04 ranging engine.
package ranger_pkg;
   localparam int DIST_W              = 10;
   localparam int TRIG_CYCLES_DEF     = 270;
   localparam int CYCLES_PER_CM_DEF   = 1574;
   localparam int TIMEOUT_CYCLES_DEF  = 1026000;
   localparam int HOLDOFF_CYCLES_DEF  = 1620000;
   localparam int MAX_CM_DEF          = 1023;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_DONE,
      S_HOLDOFF
   } ranger_state_t;
endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous echo pin with registered rise/fall pulses.
// Latency: pin edge to rise/fall pulse is 3 clocks; no backpressure.
module echo_sync (
   input  logic clk,
   input  logic rst,
   input  logic ech,
   output logic ech_s,
   output logic rise,
   output logic fall
);
   logic meta;
   logic ech_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta  <= 1'b0;
         ech_s <= 1'b0;
         ech_d <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         meta  <= ech;
         ech_s <= meta;
         ech_d <= ech_s;
         rise  <= ech_s & ~ech_d;
         fall  <= ~ech_s & ech_d;
      end
   end
endmodule

// File: rtl/ultrasonic_ranger.sv
// Single-shot HC-SR04 ranger: trigger, time the echo, convert to cm with a one-cycle valid strobe.
// Latency: result 4 clocks after the echo falls; no backpressure, start is ignored while busy.
module ultrasonic_ranger
   import ranger_pkg::*;
#(
   parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
   parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
   parameter int MAX_CM         = MAX_CM_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ech,
   output logic              trig,
   output logic              busy,
   output logic [DIST_W-1:0] distance_cm,
   output logic              dist_valid,
   output logic              timeout
);
   localparam int TRIG_W = $clog2(TRIG_CYCLES);
   localparam int PRE_W  = $clog2(CYCLES_PER_CM);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
   localparam int HOLD_W = $clog2(HOLDOFF_CYCLES);

   localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYCLES_PER_CM - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam logic [DIST_W-1:0] MAX_V     = DIST_W'(MAX_CM);

   ranger_state_t     state, state_nxt;
   logic [TRIG_W-1:0] trig_cnt;
   logic [PRE_W-1:0]  pre_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [DIST_W-1:0] acc, acc_nxt;
   logic              pre_wrap;
   logic              tmo_flag;
   logic              armed;
   logic              ech_s, rise, fall;

   echo_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .ech   (ech),
      .ech_s (ech_s),
      .rise  (rise),
      .fall  (fall)
   );

   // Rise and fall share the same sync delay, so MEASURE lasts exactly the echo width:
   // every MEASURE clock, including the one that sees the fall, is an echo-high clock.
   always_comb begin
      pre_wrap = (pre_cnt == PRE_LAST);
      acc_nxt  = (pre_wrap && acc != MAX_V) ? acc + 1'b1 : acc;
   end

   always_comb begin
      state_nxt  = state;
      trig       = 1'b0;
      busy       = 1'b1;
      dist_valid = 1'b0;
      timeout    = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_TRIG;
         end
         S_TRIG: begin
            trig = 1'b1;
            if (trig_cnt == TRIG_LAST) state_nxt = S_WAIT_RISE;
         end
         S_WAIT_RISE: begin
            if (rise && armed)            state_nxt = S_MEASURE;
            else if (tmo_cnt == TMO_LAST) state_nxt = S_DONE;
         end
         S_MEASURE: begin
            if (fall || tmo_cnt == TMO_LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            dist_valid = 1'b1;
            timeout    = tmo_flag;
            state_nxt  = S_HOLDOFF;
         end
         S_HOLDOFF: begin
            if (hold_cnt == HOLD_LAST) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         trig_cnt    <= '0;
         pre_cnt     <= '0;
         tmo_cnt     <= '0;
         hold_cnt    <= '0;
         acc         <= '0;
         tmo_flag    <= 1'b0;
         armed       <= 1'b0;
         distance_cm <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               trig_cnt <= '0;
               pre_cnt  <= '0;
               tmo_cnt  <= '0;
               acc      <= '0;
               tmo_flag <= 1'b0;
               armed    <= 1'b0;
            end
            S_TRIG: trig_cnt <= trig_cnt + 1'b1;
            S_WAIT_RISE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // An echo already high on entry must drop before a rise counts.
               if (!ech_s) armed <= 1'b1;
               if (rise && armed) begin
                  tmo_cnt <= '0;
                  pre_cnt <= '0;
                  acc     <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  distance_cm <= MAX_V;
                  tmo_flag    <= 1'b1;
               end
            end
            S_MEASURE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
               acc     <= acc_nxt;
               if (fall) begin
                  distance_cm <= acc_nxt;
               end else if (tmo_cnt == TMO_LAST) begin
                  distance_cm <= MAX_V;
                  tmo_flag    <= 1'b1;
               end
            end
            S_DONE:    hold_cnt <= '0;
            S_HOLDOFF: hold_cnt <= hold_cnt + 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with a result scoreboard and reduced timing parameters.
module tb_ultrasonic_ranger;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       ech;
   logic       trig;
   logic       busy;
   logic [9:0] distance_cm;
   logic       dist_valid;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [9:0] d;
      logic       t;
   } exp_t;

   exp_t exp_q[$];
   exp_t got_e;

   always #5 clk = ~clk;

   ultrasonic_ranger #(
      .TRIG_CYCLES    (10),
      .CYCLES_PER_CM  (20),
      .TIMEOUT_CYCLES (2000),
      .HOLDOFF_CYCLES (50),
      .MAX_CM         (63)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ech         (ech),
      .trig        (trig),
      .busy        (busy),
      .distance_cm (distance_cm),
      .dist_valid  (dist_valid),
      .timeout     (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [9:0] d, input logic t);
      exp_t e;
      e.d = d;
      e.t = t;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every result strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && dist_valid) begin
         chk("sb_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            got_e = exp_q.pop_front();
            chk("sb_dist", distance_cm, got_e.d);
            chk("sb_tmo", timeout, got_e.t);
         end
      end
   end

   // width == 0 means no echo at all.
   task automatic measure(input string tag, input int dly, input int width,
                          input logic [9:0] ed, input logic et);
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (trig && n < 100) begin
         n++;
         tick();
      end
      chk({tag, "_trig_len"}, n, 10);
      push(ed, et);
      if (width == 0) begin
         n = 0;
         while (!dist_valid && n < 3000) begin
            n++;
            tick();
         end
         chk({tag, "_tmo_latency"}, n, 2000);
         chk({tag, "_tmo_strobe"}, timeout, 1);
      end else begin
         repeat (dly) tick();
         ech = 1'b1;
         repeat (width) tick();
         ech = 1'b0;
         if (width < 2000) begin
            n = 0;
            while (!dist_valid && n < 100) begin
               n++;
               tick();
            end
            chk({tag, "_fall_to_valid"}, n, 4);
         end
      end
      n = 0;
      while (busy && n < 5000) begin
         n++;
         tick();
      end
      chk({tag, "_back_idle"}, busy, 0);
      chk({tag, "_sb_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int trig_seen;
      rst   = 1'b1;
      start = 1'b0;
      ech   = 1'b0;
      repeat (3) tick();
      chk("rst_trig", trig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", dist_valid, 0);
      chk("rst_tmo", timeout, 0);
      chk("rst_dist", distance_cm, 0);
      rst = 1'b0;
      repeat (2) tick();

      measure("basic", 30, 200, 10'd10, 1'b0);
      measure("q19", 5, 19, 10'd0, 1'b0);
      measure("q20", 5, 20, 10'd1, 1'b0);
      measure("q39", 5, 39, 10'd1, 1'b0);
      measure("q40", 5, 40, 10'd2, 1'b0);
      measure("noecho", 0, 0, 10'd63, 1'b1);
      measure("stuck", 10, 3000, 10'd63, 1'b1);
      repeat (5) tick();
      measure("clean", 10, 100, 10'd5, 1'b0);
      measure("sat", 10, 1300, 10'd63, 1'b0);

      // Reset in the middle of the trigger pulse.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("midtrig_trig_high", trig, 1);
      rst = 1'b1;
      tick();
      chk("midrst_trig", trig, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", dist_valid, 0);
      chk("midrst_tmo", timeout, 0);
      chk("midrst_dist", distance_cm, 0);
      rst = 1'b0;
      tick();

      // Echo while idle must not produce a result.
      ech = 1'b1;
      repeat (30) tick();
      ech = 1'b0;
      repeat (10) tick();
      chk("idle_echo_busy", busy, 0);

      // start held through HOLDOFF only retriggers on IDLE entry.
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (trig && n < 100) begin
         n++;
         tick();
      end
      repeat (5) tick();
      push(10'd3, 1'b0);
      ech = 1'b1;
      repeat (60) tick();
      ech = 1'b0;
      n = 0;
      while (!dist_valid && n < 100) begin
         n++;
         tick();
      end
      chk("hold_valid_seen", dist_valid, 1);
      start = 1'b1;
      n = 0;
      trig_seen = 0;
      while (busy && n < 200) begin
         if (trig) trig_seen++;
         n++;
         tick();
      end
      chk("hold_len", n, 51);
      chk("hold_no_trig", trig_seen, 0);
      chk("hold_idle_trig", trig, 0);
      tick();
      chk("hold_retrig_trig", trig, 1);
      chk("hold_retrig_busy", busy, 1);
      start = 1'b0;
      push(10'd63, 1'b1);
      n = 0;
      while (busy && n < 3000) begin
         n++;
         tick();
      end
      chk("retrig_back_idle", busy, 0);
      chk("retrig_sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
